// File: rtl/mult8x8_seq_ctrl.sv
// mult8x8_seq_ctrl: sequential 8x8 unsigned multiplier controller.
// Builds a 16-bit product from four 4x4 nibble partial products, one per
// compute state, placed with a 0/4/8-bit left shift and summed into a
// 16-bit accumulator. Nibble selects and shift code are exposed for the
// shared datapath and for observation.
module mult8x8_seq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [15:0] product,
  output logic        done,
  output logic        busy,
  output logic        zero,
  output logic        sel_a,
  output logic        sel_b,
  output logic [1:0]  shift_cntrl,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LSB     = 3'd1,
    MID1    = 3'd2,
    MID2    = 3'd3,
    MSB     = 3'd4,
    DONE_ST = 3'd5
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic [15:0] acc_r;
  logic [15:0] product_r;
  logic        done_r;
  logic        zero_r;

  logic [3:0]  a_nib_s;
  logic [3:0]  b_nib_s;
  logic [7:0]  pp_s;
  logic [15:0] shifted_s;
  logic [15:0] acc_sum_s;

  // State register; illegal codes fall back to IDLE via next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and datapath control decode from the current state.
  always_comb begin
    next_state_s = IDLE;
    sel_a        = 1'b0;
    sel_b        = 1'b0;
    shift_cntrl  = 2'b00;
    busy         = 1'b1;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          next_state_s = LSB;
        end else begin
          next_state_s = IDLE;
        end
      end
      LSB: begin
        next_state_s = MID1;
      end
      MID1: begin
        sel_a        = 1'b1;
        shift_cntrl  = 2'b01;
        next_state_s = MID2;
      end
      MID2: begin
        sel_b        = 1'b1;
        shift_cntrl  = 2'b01;
        next_state_s = MSB;
      end
      MSB: begin
        sel_a        = 1'b1;
        sel_b        = 1'b1;
        shift_cntrl  = 2'b10;
        next_state_s = DONE_ST;
      end
      DONE_ST: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Nibble partial product and its placement into the 16-bit word.
  always_comb begin
    a_nib_s = sel_a ? a_r[7:4] : a_r[3:0];
    b_nib_s = sel_b ? b_r[7:4] : b_r[3:0];
    pp_s    = {4'b0000, a_nib_s} * {4'b0000, b_nib_s};
    case (shift_cntrl)
      2'b01:   shifted_s = {4'b0000, pp_s, 4'b0000};
      2'b10:   shifted_s = {pp_s, 8'b0000_0000};
      default: shifted_s = {8'b0000_0000, pp_s};
    endcase
    acc_sum_s = acc_r + shifted_s;
  end

  // Operand capture, accumulation and result registers. The result is
  // loaded on the edge entering DONE so product/done/zero are valid
  // during the DONE cycle itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r       <= 8'h00;
      b_r       <= 8'h00;
      acc_r     <= 16'h0000;
      product_r <= 16'h0000;
      done_r    <= 1'b0;
      zero_r    <= 1'b1;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r <= dataa;
            b_r <= datab;
          end
        end
        LSB: begin
          acc_r <= shifted_s;
        end
        MID1, MID2: begin
          acc_r <= acc_sum_s;
        end
        MSB: begin
          acc_r     <= acc_sum_s;
          product_r <= acc_sum_s;
          zero_r    <= (acc_sum_s == 16'h0000);
          done_r    <= 1'b1;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign product   = product_r;
  assign done      = done_r;
  assign zero      = zero_r;
  assign state_out = state_r;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Directed and random checks for mult8x8_seq_ctrl. Inputs are driven and
// outputs sampled on the falling edge; expected values are hand-computed
// constants or the plain a*b reference.
module tb_mult8x8_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [15:0] product;
  logic        done;
  logic        busy;
  logic        zero;
  logic        sel_a;
  logic        sel_b;
  logic [1:0]  shift_cntrl;
  logic [2:0]  state_out;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;

  mult8x8_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dataa       (dataa),
    .datab       (datab),
    .product     (product),
    .done        (done),
    .busy        (busy),
    .zero        (zero),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .shift_cntrl (shift_cntrl),
    .state_out   (state_out)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Running count of done pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One multiply from IDLE: checks per-cycle controls, latency, result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] exp_p;
    logic [1:0]  shift_tbl [1:4];
    logic [1:0]  sel_tbl   [1:4];
    int cyc;
    shift_tbl[1] = 2'b00; shift_tbl[2] = 2'b01; shift_tbl[3] = 2'b01; shift_tbl[4] = 2'b10;
    sel_tbl[1]   = 2'b00; sel_tbl[2]   = 2'b10; sel_tbl[3]   = 2'b01; sel_tbl[4]   = 2'b11;
    exp_p = 16'(a) * 16'(b);
    dataa = a;
    datab = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 12) begin
      if (cyc <= 4) begin
        check_val("shift", 32'(shift_cntrl), 32'(shift_tbl[cyc]));
        check_val("sel", 32'({sel_a, sel_b}), 32'(sel_tbl[cyc]));
        check_val("busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      cyc++;
    end
    check_val("latency", 32'(cyc), 32'd5);
    check_val("product", 32'(product), 32'(exp_p));
    check_val("zero", 32'(zero), 32'(exp_p == 16'h0000));
    check_val("state_done", 32'(state_out), 32'd5);
    @(negedge clk);
    check_val("done_low", 32'(done), 32'd0);
    check_val("state_idle", 32'(state_out), 32'd0);
  endtask

  initial begin
    int dn;
    int busy_lo;
    int dbl;
    int last_done;
    int base_cnt;
    logic prev_done;
    logic [15:0] prod_at_done;

    reset = 1'b1;
    start = 1'b0;
    dataa = 8'h00;
    datab = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_product", 32'(product), 32'h0);
    check_val("rst_zero", 32'(zero), 32'd1);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_state", 32'(state_out), 32'd0);
    check_val("rst_ctl", 32'({sel_a, sel_b, shift_cntrl}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic directed products.
    run_op(8'h12, 8'h34);
    check_val("p_12x34", 32'(product), 32'h03A8);
    run_op(8'hFF, 8'hFF);
    check_val("p_FFxFF", 32'(product), 32'hFE01);
    run_op(8'h00, 8'hAB);
    check_val("p_00xAB", 32'(product), 32'h0000);
    check_val("z_00xAB", 32'(zero), 32'd1);

    // Start and operand changes while busy are ignored.
    dataa = 8'h0F; datab = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("in_mid1", 32'(state_out), 32'd2);
    start = 1'b1; dataa = 8'h02; datab = 8'h02;
    @(negedge clk);
    start = 1'b0; dataa = 8'h77; datab = 8'h99;
    dn = 0;
    prod_at_done = 16'h0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) begin
        dn++;
        prod_at_done = product;
      end
    end
    check_val("ign_done_cnt", 32'(dn), 32'd1);
    check_val("ign_product", 32'(prod_at_done), 32'h00F0);
    check_val("ign_state", 32'(state_out), 32'd0);
    check_val("ign_busy", 32'(busy), 32'd0);

    // Start held high: back-to-back operations every 6 cycles.
    dataa = 8'h80; datab = 8'h02; start = 1'b1;
    @(negedge clk);
    dn = 0; busy_lo = 0; dbl = 0; last_done = 0; prev_done = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      if (done) begin
        dn++;
        check_val("b2b_product", 32'(product), 32'h0100);
        if (last_done != 0) check_val("b2b_spacing", 32'(c - last_done), 32'd6);
        last_done = c;
      end
      if (!busy) busy_lo++;
      if (done && prev_done) dbl++;
      prev_done = done;
      if (c == 17) start = 1'b0;
      @(negedge clk);
    end
    check_val("b2b_done_cnt", 32'(dn), 32'd3);
    check_val("b2b_busy_lo", 32'(busy_lo), 32'd2);
    check_val("b2b_double_done", 32'(dbl), 32'd0);
    check_val("b2b_idle", 32'(state_out), 32'd0);
    @(negedge clk);

    // Reset in the middle of an operation.
    run_op(8'h12, 8'h34);
    dataa = 8'hFF; datab = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dn = 0;
    while (state_out != 3'd3 && dn < 10) begin
      @(negedge clk);
      dn++;
    end
    check_val("reach_mid2", 32'(state_out), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mrst_state", 32'(state_out), 32'd0);
    check_val("mrst_product", 32'(product), 32'h0);
    check_val("mrst_busy", 32'(busy), 32'd0);
    check_val("mrst_done", 32'(done), 32'd0);
    check_val("mrst_zero", 32'(zero), 32'd1);
    @(negedge clk);
    check_val("mrst_no_done", 32'(done), 32'd0);
    run_op(8'h03, 8'h05);
    check_val("p_03x05", 32'(product), 32'h000F);

    // Random operand sweep against a*b.
    base_cnt = done_cnt;
    for (int k = 0; k < 1000; k++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    check_val("sweep_done_cnt", 32'(done_cnt - base_cnt), 32'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
